shift_request_scheduler: RTL and testbench

Shares one base-3 barrel shifter between two requesters using round-robin arbitration.
- Accepts shift requests with a binary shift amount (0..15).
- Converts the amount into three base-3 digit selects and drives the shifter.
- Waits a parameterised shifter latency, then returns the tagged result over a valid/ready response port.
- Sits between the ALU issue logic and the shifter datapath.

---
 rtl/shift_request_scheduler.sv | 103 ++++++++++
 tb/tb_shift_request_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_request_scheduler.sv
// shift_request_scheduler: round-robin sharing of one base-3 barrel shifter between two requesters,
// with amount-to-digit conversion, a fixed shifter latency wait and a valid/ready response port.
module shift_request_scheduler #(
  parameter int SHIFT_LAT = 0,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [3:0]       req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [3:0]       req1_amt,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] sh_data,
  output logic [1:0]       sh_op,
  output logic [1:0]       sh_base3_0,
  output logic [1:0]       sh_base3_1,
  output logic [1:0]       sh_base3_2,
  input  logic [WIDTH-1:0] sh_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic             busy
);
  localparam int CW = $clog2(SHIFT_LAT + 2);
  typedef enum logic [1:0] {IDLE, CONV, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic last, g1, acc, wait_done;
  logic [1:0] in_op, op, d0, d1, d2;
  logic [3:0] amt, r;
  logic [WIDTH-1:0] data;
  logic [CW-1:0] cnt;
  // last = 1 means requester 1 won the previous grant, so requester 0 wins a tie
  always_comb begin
    g1 = req1_valid & (~req0_valid | ~last);
    req0_ready = (state == IDLE) & req0_valid & ~g1;
    req1_ready = (state == IDLE) & g1;
    acc = req0_ready | req1_ready;
    in_op = g1 ? req1_op : req0_op;
    wait_done = cnt == CW'(SHIFT_LAT);
    resp_valid = state == RESP;
    busy = state != IDLE;
    state_nx = state == IDLE ? (acc ? (in_op == 2'b11 ? RESP : CONV) : IDLE) :
               state == CONV ? WAIT :
               state == WAIT ? (wait_done ? RESP : WAIT) :
               (resp_ready ? IDLE : RESP);
  end
  always_comb begin
    d2 = {1'b0, amt >= 4'd9};
    r = amt >= 4'd9 ? amt - 4'd9 : amt;
    d1 = r >= 4'd6 ? 2'd2 : r >= 4'd3 ? 2'd1 : 2'd0;
    d0 = 2'(r >= 4'd6 ? r - 4'd6 : r >= 4'd3 ? r - 4'd3 : r);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      data <= '0;
      amt <= '0;
      op <= '0;
      cnt <= '0;
      sh_data <= '0;
      sh_op <= '0;
      sh_base3_0 <= '0;
      sh_base3_1 <= '0;
      sh_base3_2 <= '0;
      resp_data <= '0;
      resp_id <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (acc) begin
        data <= g1 ? req1_data : req0_data;
        amt <= g1 ? req1_amt : req0_amt;
        op <= in_op;
        last <= g1;
        resp_id <= g1;
        resp_err <= in_op == 2'b11;
        resp_data <= '0;
      end
      if (state == CONV) begin
        sh_data <= data;
        sh_op <= op;
        sh_base3_0 <= d0;
        sh_base3_1 <= d1;
        sh_base3_2 <= d2;
        cnt <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (wait_done) resp_data <= sh_result;
      end
    end
  end
endmodule

// File: tb/tb_shift_request_scheduler.sv
// tb_shift_request_scheduler: directed and random requests scored against a queue-based
// reference of arbitration, latency and shift results; the shifter itself is a bench model.
module tb_shift_request_scheduler;
  localparam int SHIFT_LAT = 0;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [15:0] req0_data = 0, req1_data = 0, sh_data, sh_result, resp_data;
  logic [3:0] req0_amt = 0, req1_amt = 0;
  logic [1:0] req0_op = 0, req1_op = 0, sh_op, sh_base3_0, sh_base3_1, sh_base3_2;
  logic resp_valid, resp_ready = 1, resp_id, resp_err, busy;
  always #5 clk = ~clk;

  shift_request_scheduler #(.SHIFT_LAT(SHIFT_LAT), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt), .req1_op(req1_op),
    .sh_data(sh_data), .sh_op(sh_op), .sh_base3_0(sh_base3_0), .sh_base3_1(sh_base3_1), .sh_base3_2(sh_base3_2),
    .sh_result(sh_result), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  function automatic logic [15:0] shf(input logic [15:0] d, input int a, input logic [1:0] o);
    logic signed [15:0] s;
    s = d;
    if (o == 2'd0) return d << a;
    if (o == 2'd1) return d >> a;
    if (o == 2'd2) return s >>> a;
    return '0;
  endfunction

  function automatic logic [5:0] digits(input int a);
    return {2'(a / 9), 2'((a % 9) / 3), 2'(a % 3)};
  endfunction

  assign sh_result = shf(sh_data, int'(sh_base3_0) + 3 * int'(sh_base3_1) + 9 * int'(sh_base3_2), sh_op);

  typedef struct {
    logic id;
    logic err;
    logic [15:0] res;
    logic [15:0] din;
    logic [3:0] amt;
    logic [1:0] op;
  } exp_t;
  exp_t q[$];
  bit inflight, seen, acc0, acc1;
  bit last = 1;
  int cyc, acc_cyc, n_vec, n_err;
  logic [15:0] sh_last_data;
  logic [1:0] sh_last_op;
  logic [5:0] sh_last_dig;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // reference: arbitration, busy, response contents, latency and shifter drive
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      inflight = 0; seen = 0; last = 1; acc0 = 0; acc1 = 0;
      sh_last_data = 0; sh_last_op = 0; sh_last_dig = 0;
    end else begin
      cyc++;
      check("ready0", req0_ready, !inflight && req0_valid && (!req1_valid || last));
      check("ready1", req1_ready, !inflight && req1_valid && (!req0_valid || !last));
      check("busy", busy, inflight);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (resp_valid) begin
        if (q.size() == 0) check("resp_unexpected", resp_valid, 0);
        else begin
          check("resp_data", resp_data, q[0].res);
          check("resp_id", resp_id, q[0].id);
          check("resp_err", resp_err, q[0].err);
          if (!seen) begin
            check("latency", cyc - acc_cyc, q[0].err ? 1 : 3 + SHIFT_LAT);
            seen = 1;
          end
          if (!q[0].err) begin
            sh_last_data = q[0].din; sh_last_op = q[0].op; sh_last_dig = digits(q[0].amt);
          end
          check("sh_data", sh_data, sh_last_data);
          check("sh_op", sh_op, sh_last_op);
          check("sh_digits", {sh_base3_2, sh_base3_1, sh_base3_0}, sh_last_dig);
          if (resp_ready) begin
            void'(q.pop_front());
            inflight = 0;
          end
        end
      end
      if (acc0 || acc1) begin
        e.id = acc1;
        e.din = acc1 ? req1_data : req0_data;
        e.amt = acc1 ? req1_amt : req0_amt;
        e.op = acc1 ? req1_op : req0_op;
        e.err = e.op == 2'b11;
        e.res = e.err ? 16'h0 : shf(e.din, e.amt, e.op);
        q.push_back(e);
        inflight = 1; seen = 0; acc_cyc = cyc; last = acc1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
    if (i == 0) begin req0_valid = 1; req0_data = d; req0_amt = a; req0_op = o; end
    else begin req1_valid = 1; req1_data = d; req1_amt = a; req1_op = o; end
  endtask

  task automatic drop(input int i);
    if (i == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 16'($urandom), 4'($urandom), $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2)));
  endtask

  task automatic req(input int i, input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
    set_req(i, d, a, o);
    for (int k = 0; k < 64; k++) begin
      tick();
      if (i == 0 ? acc0 : acc1) begin
        drop(i);
        return;
      end
    end
    check("accept_timeout", i == 0 ? acc0 : acc1, 1);
    drop(i);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (!inflight) return;
      tick();
    end
    check("drain_timeout", inflight, 0);
  endtask

  task automatic both(input int n);
    int cnt = 0;
    set_rand(0);
    set_rand(1);
    for (int k = 0; k < 200 && cnt < n; k++) begin
      tick();
      if (acc0) begin cnt++; set_rand(0); end
      if (acc1) begin cnt++; set_rand(1); end
    end
    drop(0);
    drop(1);
    check("both_count", cnt, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_resp"}, {resp_valid, resp_id, resp_err, busy, resp_data}, 0);
    check({tag, "_sh"}, {sh_data, sh_op, sh_base3_2, sh_base3_1, sh_base3_0}, 0);
    check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    tick();
    req(0, 16'h0001, 4'd13, 2'd0);
    drain();
    check("tp1_digits", {sh_base3_2, sh_base3_1, sh_base3_0}, 6'b01_01_01);
    req(1, 16'h8000, 4'd15, 2'd2);
    drain();
    check("tp2_digits", {sh_base3_2, sh_base3_1, sh_base3_0}, 6'b01_10_00);
    for (int a = 0; a < 16; a++) begin
      req(0, 16'($urandom), 4'(a), 2'd1);
      drain();
      check("sweep_digits", {sh_base3_2, sh_base3_1, sh_base3_0}, digits(a));
    end
    both(4);
    drain();
    req(0, 16'h1234, 4'd5, 2'd3);
    drain();
    req(1, 16'h00f0, 4'd4, 2'd0);
    drain();
    resp_ready = 0;
    req(0, 16'hbeef, 4'd7, 2'd2);
    repeat (10) tick();
    resp_ready = 1;
    drain();
    req(1, 16'h0f0f, 4'd9, 2'd1);
    tick();
    rst_n = 0;
    #2;
    check_zero("midrst");
    tick();
    rst_n = 1;
    tick();
    both(2);
    drain();
    for (int c = 0; c < 800; c++) begin
      tick();
      if (req0_valid && acc0) drop(0);
      if (req1_valid && acc1) drop(1);
      if (!req0_valid) begin if ($urandom_range(0, 2) == 0) set_rand(0); end
      else if (!acc0 && $urandom_range(0, 19) == 0) drop(0);
      if (!req1_valid) begin if ($urandom_range(0, 2) == 0) set_rand(1); end
      else if (!acc1 && $urandom_range(0, 19) == 0) drop(1);
      resp_ready = $urandom_range(0, 3) != 0;
    end
    drop(0);
    drop(1);
    resp_ready = 1;
    tick();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
